time_set_ctrl: RTL and testbench

//  Time-setting controller and display formatter for the HH:MM:SS clock.
//  - Sits between the debounce/counter stage and the 8-digit display driver.
//  - Takes debounced buttons and the live time; runs a RUN/SET mode FSM that edits
//    a shadow copy of the time, then loads the edited time back into the counter.
//  - Produces the eight registered digit words consumed by dspl_drv_8dig.

---
 rtl/clock_pkg.sv | 14 +
 rtl/bin2bcd_2dig.sv | 33 +++
 rtl/time_set_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the HH:MM:SS time-setting controller.
// Config-state encoding, field limits and the {en, hex, dp} digit-word builder.
package clock_pkg;

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} cfg_state_t;

  localparam logic [4:0] HOURS_MAX  = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  function automatic logic [5:0] mk_digit(input logic en, input logic [3:0] val, input logic dp);
    return {en, val, dp};
  endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Two-digit binary-to-BCD split for values 0..63.
// Purely combinational, no latency and no handshake.
module bin2bcd_2dig (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  always_comb begin
    tens_o  = 4'd0;
    units_o = bin_i[3:0];
    if (bin_i >= 6'd60) begin
      tens_o  = 4'd6;
      units_o = 4'(bin_i - 6'd60);
    end else if (bin_i >= 6'd50) begin
      tens_o  = 4'd5;
      units_o = 4'(bin_i - 6'd50);
    end else if (bin_i >= 6'd40) begin
      tens_o  = 4'd4;
      units_o = 4'(bin_i - 6'd40);
    end else if (bin_i >= 6'd30) begin
      tens_o  = 4'd3;
      units_o = 4'(bin_i - 6'd30);
    end else if (bin_i >= 6'd20) begin
      tens_o  = 4'd2;
      units_o = 4'(bin_i - 6'd20);
    end else if (bin_i >= 6'd10) begin
      tens_o  = 4'd1;
      units_o = 4'(bin_i - 6'd10);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// RUN/SET mode controller editing a shadow time and formatting 8 digit words (optional blink).
// Latency: digit words registered, 1 cycle after source change; load_o is a registered 1-cycle pulse.
// Backpressure: none; buttons are level inputs edge-detected internally, hold_o freezes the counter.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 25_000_000
)
(
    input  logic       clk_100MHz_i,
    input  logic       rstn_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       mode_i,
    input  logic [4:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    output logic       hold_o,
    output logic       load_o,
    output logic [4:0] load_hours_o,
    output logic [5:0] load_minutes_o,
    output logic [5:0] load_seconds_o,
    output logic [5:0] d1_o,
    output logic [5:0] d2_o,
    output logic [5:0] d3_o,
    output logic [5:0] d4_o,
    output logic [5:0] d5_o,
    output logic [5:0] d6_o,
    output logic [5:0] d7_o,
    output logic [5:0] d8_o
);

    cfg_state_t state_q, state_d;
    logic       inc_q, dec_q, mode_q;
    logic [4:0] sh_h_q, sh_h_d;
    logic [5:0] sh_m_q, sh_m_d;
    logic [5:0] sh_s_q, sh_s_d;
    logic       hold_q, hold_d;
    logic       load_q, load_d;
    logic [4:0] ld_h_q, ld_h_d;
    logic [5:0] ld_m_q, ld_m_d;
    logic [5:0] ld_s_q, ld_s_d;
    logic [5:0] d1_q, d2_q, d4_q, d5_q, d7_q, d8_q;
    logic [5:0] d1_d, d2_d, d4_d, d5_d, d7_d, d8_d;

    logic inc_p, dec_p, mode_p, step_inc, step_dec;
    logic [4:0] src_h;
    logic [5:0] src_m, src_s;
    logic [3:0] h_tens, h_units, m_tens, m_units, s_tens, s_units;
    logic       blank_h, blank_m, blank_s, set_mode;

    assign inc_p    = inc_i & ~inc_q;
    assign dec_p    = dec_i & ~dec_q;
    assign mode_p   = mode_i & ~mode_q;
    // Mode has priority; simultaneous inc+dec cancel each other.
    assign step_inc = inc_p & ~dec_p & ~mode_p;
    assign step_dec = dec_p & ~inc_p & ~mode_p;

    always_comb begin
        state_d = state_q;
        sh_h_d  = sh_h_q;
        sh_m_d  = sh_m_q;
        sh_s_d  = sh_s_q;
        load_d  = 1'b0;
        ld_h_d  = ld_h_q;
        ld_m_d  = ld_m_q;
        ld_s_d  = ld_s_q;
        case (state_q)
            RUN: begin
                if (mode_p) begin
                    state_d = SET_H;
                    sh_h_d  = hours_i;
                    sh_m_d  = minutes_i;
                    sh_s_d  = seconds_i;
                end
            end
            SET_H: begin
                if (mode_p)        state_d = SET_M;
                else if (step_inc) sh_h_d = (sh_h_q == HOURS_MAX) ? 5'd0 : sh_h_q + 5'd1;
                else if (step_dec) sh_h_d = (sh_h_q == 5'd0) ? HOURS_MAX : sh_h_q - 5'd1;
            end
            SET_M: begin
                if (mode_p)        state_d = SET_S;
                else if (step_inc) sh_m_d = (sh_m_q == MINSEC_MAX) ? 6'd0 : sh_m_q + 6'd1;
                else if (step_dec) sh_m_d = (sh_m_q == 6'd0) ? MINSEC_MAX : sh_m_q - 6'd1;
            end
            SET_S: begin
                if (mode_p) begin
                    state_d = RUN;
                    load_d  = 1'b1;
                    ld_h_d  = sh_h_q;
                    ld_m_d  = sh_m_q;
                    ld_s_d  = sh_s_q;
                end
                else if (step_inc) sh_s_d = (sh_s_q == MINSEC_MAX) ? 6'd0 : sh_s_q + 6'd1;
                else if (step_dec) sh_s_d = (sh_s_q == 6'd0) ? MINSEC_MAX : sh_s_q - 6'd1;
            end
            default: state_d = RUN;
        endcase
        // Hold stays up through the load pulse so the counter never ticks before loading.
        hold_d = (state_d != RUN) | load_d;
    end

    always_ff @(posedge clk_100MHz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= RUN;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            mode_q  <= 1'b0;
            sh_h_q  <= '0;
            sh_m_q  <= '0;
            sh_s_q  <= '0;
            hold_q  <= 1'b0;
            load_q  <= 1'b0;
            ld_h_q  <= '0;
            ld_m_q  <= '0;
            ld_s_q  <= '0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_i;
            dec_q   <= dec_i;
            mode_q  <= mode_i;
            sh_h_q  <= sh_h_d;
            sh_m_q  <= sh_m_d;
            sh_s_q  <= sh_s_d;
            hold_q  <= hold_d;
            load_q  <= load_d;
            ld_h_q  <= ld_h_d;
            ld_m_q  <= ld_m_d;
            ld_s_q  <= ld_s_d;
        end
    end

    assign set_mode = (state_q != RUN);

`ifdef CFG_BLINK_EN
    localparam int unsigned BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    logic [BCW-1:0] blink_cnt_q;
    logic           blink_phase_q;

    always_ff @(posedge clk_100MHz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if ((state_d != RUN) && (state_d != state_q)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BCW'(BLINK_CYCLES - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    assign blank_h = blink_phase_q && (state_q == SET_H);
    assign blank_m = blink_phase_q && (state_q == SET_M);
    assign blank_s = blink_phase_q && (state_q == SET_S);
`else
    assign blank_h = 1'b0;
    assign blank_m = 1'b0;
    assign blank_s = 1'b0;
`endif

    assign src_h = set_mode ? sh_h_q : hours_i;
    assign src_m = set_mode ? sh_m_q : minutes_i;
    assign src_s = set_mode ? sh_s_q : seconds_i;

    bin2bcd_2dig u_bcd_h (.bin_i({1'b0, src_h}), .tens_o(h_tens), .units_o(h_units));
    bin2bcd_2dig u_bcd_m (.bin_i(src_m),         .tens_o(m_tens), .units_o(m_units));
    bin2bcd_2dig u_bcd_s (.bin_i(src_s),         .tens_o(s_tens), .units_o(s_units));

    assign d1_d = mk_digit(~blank_s, s_units, set_mode);
    assign d2_d = mk_digit(~blank_s, s_tens,  1'b0);
    assign d4_d = mk_digit(~blank_m, m_units, 1'b0);
    assign d5_d = mk_digit(~blank_m, m_tens,  1'b0);
    assign d7_d = mk_digit(~blank_h, h_units, 1'b0);
    assign d8_d = mk_digit(~blank_h, h_tens,  1'b0);

    always_ff @(posedge clk_100MHz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            d1_q <= '0;
            d2_q <= '0;
            d4_q <= '0;
            d5_q <= '0;
            d7_q <= '0;
            d8_q <= '0;
        end else begin
            d1_q <= d1_d;
            d2_q <= d2_d;
            d4_q <= d4_d;
            d5_q <= d5_d;
            d7_q <= d7_d;
            d8_q <= d8_d;
        end
    end

    assign hold_o         = hold_q;
    assign load_o         = load_q;
    assign load_hours_o   = ld_h_q;
    assign load_minutes_o = ld_m_q;
    assign load_seconds_o = ld_s_q;
    assign d1_o = d1_q;
    assign d2_o = d2_q;
    assign d3_o = 6'b0;
    assign d4_o = d4_q;
    assign d5_o = d5_q;
    assign d6_o = 6'b0;
    assign d7_o = d7_q;
    assign d8_o = d8_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: reset, editing, wraps, load pulse, button corner cases.
// Latency: samples outputs 1 ns after each rising clock edge.
// Backpressure: none; drives level buttons and live time directly.
module tb_time_set_ctrl;

    logic       clk;
    logic       rstn;
    logic       inc, dec, mode;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic       hold, load;
    logic [4:0] ld_h;
    logic [5:0] ld_m, ld_s;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [47:0] disp;

    int errors = 0;
    int checks = 0;
    int load_cnt = 0;

    time_set_ctrl #(.BLINK_CYCLES(4)) dut (
        .clk_100MHz_i(clk), .rstn_i(rstn),
        .inc_i(inc), .dec_i(dec), .mode_i(mode),
        .hours_i(hours), .minutes_i(minutes), .seconds_i(seconds),
        .hold_o(hold), .load_o(load),
        .load_hours_o(ld_h), .load_minutes_o(ld_m), .load_seconds_o(ld_s),
        .d1_o(d1), .d2_o(d2), .d3_o(d3), .d4_o(d4),
        .d5_o(d5), .d6_o(d6), .d7_o(d7), .d8_o(d8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign disp = {d8, d7, d6, d5, d4, d3, d2, d1};

    always @(negedge clk) if (load === 1'b1) load_cnt++;

    function automatic logic [5:0] dg(input int v);
        logic [31:0] t;
        t = v;
        return {1'b1, t[3:0], 1'b0};
    endfunction

    function automatic logic [47:0] exp_disp(input int h, input int m, input int s, input logic dp);
        return {dg(h / 10), dg(h % 10), 6'b0, dg(m / 10), dg(m % 10), 6'b0,
                dg(s / 10), dg(s % 10) | {5'b0, dp}};
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_live(input int h, input int m, input int s);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
    endtask

    // which: 0=inc 1=dec 2=mode
    task automatic press(input int which);
        if (which == 0) inc = 1'b1; else if (which == 1) dec = 1'b1; else mode = 1'b1;
        tick();
        inc = 1'b0; dec = 1'b0; mode = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        set_live(12, 34, 56);
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (disp !== 48'd0) begin errors++; $display("FAIL reset_disp: got %h want 0", disp); end
        checks++;
        if ({hold, load, ld_h, ld_m, ld_s} !== 19'd0) begin
            errors++; $display("FAIL reset_ctrl: hold=%b load=%b ld=%0d/%0d/%0d want all 0", hold, load, ld_h, ld_m, ld_s);
        end
        tick(2);
        rstn = 1'b1;
        tick(2);
        checks++;
        if (disp !== exp_disp(12, 34, 56, 1'b0)) begin
            errors++; $display("FAIL run_disp: got %h want %h", disp, exp_disp(12, 34, 56, 1'b0));
        end
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL run_hold: got %b want 0", hold); end
    endtask

    task automatic test_run_ignore;
        int lc;
        lc = load_cnt;
        press(0);
        press(1);
        tick();
        checks++;
        if (disp !== exp_disp(12, 34, 56, 1'b0) || hold !== 1'b0 || load_cnt != lc) begin
            errors++; $display("FAIL run_ignore: disp=%h hold=%b loads=%0d want %h 0 %0d",
                               disp, hold, load_cnt, exp_disp(12, 34, 56, 1'b0), lc);
        end
    endtask

    task automatic test_set_hours;
        int lc;
        press(2);
        set_live(0, 0, 0);
        tick();
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL set_hold: got %b want 1", hold); end
        checks++;
        if (disp !== exp_disp(12, 34, 56, 1'b1)) begin
            errors++; $display("FAIL set_shadow: got %h want %h", disp, exp_disp(12, 34, 56, 1'b1));
        end
        for (int i = 0; i < 4; i++) press(0);
        tick();
        checks++;
        if (disp !== exp_disp(16, 34, 56, 1'b1)) begin
            errors++; $display("FAIL set_inc4: got %h want %h", disp, exp_disp(16, 34, 56, 1'b1));
        end
        lc = load_cnt;
        for (int i = 0; i < 3; i++) press(2);
        tick();
        checks++;
        if (load_cnt != lc + 1 || ld_h !== 5'd16 || ld_m !== 6'd34 || ld_s !== 6'd56) begin
            errors++; $display("FAIL set_load: loads=%0d ld=%0d/%0d/%0d want %0d 16/34/56",
                               load_cnt - lc, ld_h, ld_m, ld_s, 1);
        end
    endtask

    task automatic test_wraps;
        set_live(23, 0, 59);
        press(2);
        press(0);
        tick();
        checks++;
        if (disp !== exp_disp(0, 0, 59, 1'b1)) begin
            errors++; $display("FAIL wrap_h_inc: got %h want %h", disp, exp_disp(0, 0, 59, 1'b1));
        end
        press(1);
        tick();
        checks++;
        if (disp !== exp_disp(23, 0, 59, 1'b1)) begin
            errors++; $display("FAIL wrap_h_dec: got %h want %h", disp, exp_disp(23, 0, 59, 1'b1));
        end
        press(2);
        press(1);
        tick();
        checks++;
        if (disp !== exp_disp(23, 59, 59, 1'b1)) begin
            errors++; $display("FAIL wrap_m_dec: got %h want %h", disp, exp_disp(23, 59, 59, 1'b1));
        end
        press(2);
        press(0);
        tick();
        checks++;
        if (disp !== exp_disp(23, 59, 0, 1'b1)) begin
            errors++; $display("FAIL wrap_s_inc: got %h want %h", disp, exp_disp(23, 59, 0, 1'b1));
        end
        press(2);
        tick();
    endtask

    task automatic test_load;
        int lc;
        set_live(7, 8, 9);
        press(2);
        press(2);
        press(2);
        lc = load_cnt;
        mode = 1'b1;
        tick();
        checks++;
        if (load !== 1'b1 || hold !== 1'b1) begin
            errors++; $display("FAIL load_pulse: load=%b hold=%b want 1 1", load, hold);
        end
        checks++;
        if (ld_h !== 5'd7 || ld_m !== 6'd8 || ld_s !== 6'd9) begin
            errors++; $display("FAIL load_vals: got %0d/%0d/%0d want 7/8/9", ld_h, ld_m, ld_s);
        end
        mode = 1'b0;
        tick();
        checks++;
        if (load !== 1'b0 || hold !== 1'b0) begin
            errors++; $display("FAIL load_after: load=%b hold=%b want 0 0", load, hold);
        end
        set_live(1, 2, 3);
        tick(5);
        checks++;
        if (load_cnt != lc + 1 || disp !== exp_disp(1, 2, 3, 1'b0)) begin
            errors++; $display("FAIL load_run: pulses=%0d disp=%h want 1 %h",
                               load_cnt - lc, disp, exp_disp(1, 2, 3, 1'b0));
        end
    endtask

    task automatic test_buttons;
        set_live(10, 20, 30);
        press(2);
        inc = 1'b1; dec = 1'b1;
        tick();
        inc = 1'b0; dec = 1'b0;
        tick(2);
        checks++;
        if (disp !== exp_disp(10, 20, 30, 1'b1)) begin
            errors++; $display("FAIL inc_dec_same: got %h want %h", disp, exp_disp(10, 20, 30, 1'b1));
        end
        mode = 1'b1; inc = 1'b1;
        tick();
        mode = 1'b0; inc = 1'b0;
        tick(2);
        checks++;
        if (disp !== exp_disp(10, 20, 30, 1'b1) || hold !== 1'b1) begin
            errors++; $display("FAIL mode_inc: disp=%h hold=%b want %h 1", disp, hold, exp_disp(10, 20, 30, 1'b1));
        end
        // now in SET_M: a held inc must count once
        inc = 1'b1;
        tick(1000);
        inc = 1'b0;
        tick(2);
        checks++;
        if (disp !== exp_disp(10, 21, 30, 1'b1)) begin
            errors++; $display("FAIL inc_hold: got %h want %h", disp, exp_disp(10, 21, 30, 1'b1));
        end
    endtask

`ifdef CFG_BLINK_EN
    task automatic test_blink;
        int run_len, nruns, bad;
        logic prev_en;
        press(0);
        tick();
        prev_en = d5[5];
        run_len = 1; nruns = 0; bad = 0;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (d4[5] !== d5[5]) bad++;
            if (d5[5] === prev_en) run_len++;
            else begin
                if (nruns > 0 && run_len != 4) bad++;
                nruns++;
                run_len = 1;
                prev_en = d5[5];
            end
        end
        checks++;
        if (bad != 0 || nruns < 3) begin
            errors++; $display("FAIL blink_m: bad=%0d toggles=%0d want 0 and >=3", bad, nruns);
        end
    endtask
`endif

    task automatic test_reset_mid_set;
        int lc;
        lc = load_cnt;
        rstn = 1'b0;
        #1;
        checks++;
        if (disp !== 48'd0 || hold !== 1'b0 || load !== 1'b0 || {ld_h, ld_m, ld_s} !== 17'd0) begin
            errors++; $display("FAIL midset_reset: disp=%h hold=%b load=%b want 0 0 0", disp, hold, load);
        end
        tick(3);
        rstn = 1'b1;
        tick(3);
        checks++;
        if (load_cnt != lc || hold !== 1'b0 || disp !== exp_disp(10, 20, 30, 1'b0)) begin
            errors++; $display("FAIL midset_after: pulses=%0d hold=%b disp=%h want 0 0 %h",
                               load_cnt - lc, hold, disp, exp_disp(10, 20, 30, 1'b0));
        end
    endtask

    initial begin
        inc = 1'b0; dec = 1'b0; mode = 1'b0;
        rstn = 1'b1;
        set_live(0, 0, 0);
        test_reset();
        test_run_ignore();
        test_set_hours();
        test_wraps();
        test_load();
        test_buttons();
`ifdef CFG_BLINK_EN
        test_blink();
`endif
        test_reset_mid_set();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
